// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch unit.
//   INSTR_W / PC_W     : instruction and program-counter widths
//   HALT_WORD_DEFAULT  : default encoding that stops fetch
//   fetch_state_t      : fetch FSM state encoding
//   branch_target()    : redirect address from a signed word offset
package mips_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned OFF_W   = 16;

   localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      ISSUE = 3'd2,
      EXEC  = 3'd3,
      HALT  = 3'd4
   } fetch_state_t;

   // pc + 4 + (sign-extended word offset << 2), modulo 2^PC_W
   function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0]  cur_pc,
                                                     input logic [OFF_W-1:0] offset);
      logic [PC_W-1:0] byte_off;
      byte_off      = {{(PC_W-OFF_W-2){offset[OFF_W-1]}}, offset, 2'b00};
      branch_target = cur_pc + PC_W'(4) + byte_off;
   endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction storage: MEM_WORDS x INSTR_W words.
// Ports:
//   clock  : write clock
//   we     : write strobe (already qualified by the fetch FSM)
//   waddr  : write word address
//   wdata  : write data
//   raddr  : read word address
//   rdata  : combinational read data
// Contents are deliberately not reset so a loaded program survives reset.
module instr_mem
   import mips_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 128
) (
   input  logic                         clock,
   input  logic                         we,
   input  logic [$clog2(MEM_WORDS)-1:0] waddr,
   input  logic [INSTR_W-1:0]           wdata,
   input  logic [$clog2(MEM_WORDS)-1:0] raddr,
   output logic [INSTR_W-1:0]           rdata
);

   logic [INSTR_W-1:0] mem [MEM_WORDS];

   // Synchronous write port
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Combinational read port
   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one word per instruction period from a
// loadable instruction memory, presents it to the CPU with a one-cycle
// strobe, then waits out the execute cycles and advances or redirects pc.
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   run                   : level enable for fetching
//   load_en/addr/data     : program-load write (honoured in IDLE or HALT only)
//   branch_taken/offset   : redirect request, sampled in the final EXEC cycle
//   instrword             : registered instruction
//   newinstr              : one-cycle strobe in ISSUE
//   pc                    : byte address of instrword
//   busy                  : FETCH, ISSUE or EXEC
//   halted                : HALT reached (exit only by reset)
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned        MEM_WORDS        = 128,
   parameter int unsigned        CYCLES_PER_INSTR = 4,
   parameter logic [INSTR_W-1:0] HALT_WORD        = HALT_WORD_DEFAULT
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         run,
   input  logic                         load_en,
   input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
   input  logic [INSTR_W-1:0]           load_data,
   input  logic                         branch_taken,
   input  logic [OFF_W-1:0]             branch_offset,
   output logic [INSTR_W-1:0]           instrword,
   output logic                         newinstr,
   output logic [PC_W-1:0]              pc,
   output logic                         busy,
   output logic                         halted
);

   localparam int unsigned ADDR_W = $clog2(MEM_WORDS);
   localparam int unsigned CNT_W  = (CYCLES_PER_INSTR > 1) ? $clog2(CYCLES_PER_INSTR) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES_PER_INSTR - 1);

   fetch_state_t       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               mem_we;
   logic [ADDR_W-1:0]  mem_raddr;
   logic [INSTR_W-1:0] mem_rdata;

   // Word index wraps modulo MEM_WORDS by dropping the upper pc bits
   assign mem_raddr = pc_q[ADDR_W+1:2];

   instr_mem #(
      .MEM_WORDS (MEM_WORDS)
   ) u_mem (
      .clock (clock),
      .we    (mem_we),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   // State and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      mem_we  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A pending load holds off fetch so the write lands first
            mem_we = load_en;
            if (run && !load_en) begin
               state_d = FETCH;
            end
         end

         FETCH: begin
            if (mem_rdata == HALT_WORD) begin
               state_d = HALT;
            end else begin
               instr_d = mem_rdata;
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = EXEC;
         end

         EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Only the final execute cycle looks at the redirect request
               pc_d    = branch_taken ? branch_target(pc_q, branch_offset)
                                      : pc_q + PC_W'(4);
               state_d = run ? FETCH : IDLE;
            end
         end

         HALT: begin
            mem_we = load_en;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status strobes are pure decodes of the state register
   assign newinstr  = (state_q == ISSUE);
   assign busy      = (state_q == FETCH) || (state_q == ISSUE) || (state_q == EXEC);
   assign halted    = (state_q == HALT);
   assign pc        = pc_q;
   assign instrword = instr_q;

endmodule
